raster_line_scanout: RTL

- Downstream consumer of the video-in pixel stream in the projector system; runs on the pixel clock.
- Buffers incoming pixels one line at a time in a ping-pong pair of line buffers.
- Replays each line to the laser driver once per polygon-mirror facet sync, after a fixed delay.
- Flags underflow, sync overrun and malformed frames.

---
 rtl/raster_line_scanout.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/raster_line_scanout.sv
// Ping-pong line buffer between the video-in pixel stream and the laser driver.
// Each buffered line is replayed once per facet sync edge, after a fixed delay.
module raster_line_scanout #(
  parameter int DATA_W       = 8,
  parameter int H_PIXELS     = 640,
  parameter int V_LINES      = 480,
  parameter int DELAY_CYCLES = 64,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              pixel_clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] sink_data,
  input  logic              sink_valid,
  input  logic              sink_startofpacket,
  input  logic              sink_endofpacket,
  output logic              sink_ready,
  input  logic              facet_sync_in,
  output logic [DATA_W-1:0] laser_data,
  output logic              laser_en,
  output logic [15:0]       line_index,
  output logic              frame_start,
  output logic              line_done,
  output logic              underflow,
  output logic              sync_overrun,
  output logic              sop_err
);
  localparam int COL_W = $clog2(H_PIXELS + 1);
  localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  typedef enum logic [1:0] {WAIT_SYNC, DELAY, SCAN} state_t;

  logic [DATA_W-1:0] buf0_q [H_PIXELS];
  logic [DATA_W-1:0] buf1_q [H_PIXELS];

  logic [1:0]       full_q, full_d, first_q;
  logic             wsel_q, wsel_d, ready_q, ready_d;
  logic [COL_W-1:0] wcol_q, wr_col, wr_next;
  logic             wr_fire, sop_mid, line_fill, buf_free;
  logic             eop_unused;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [COL_W-1:0] rcol_q, rd_addr;
  logic             rsel_q, rd_en;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q, sync_edge;

  logic [DATA_W-1:0] rdata_p1, laser_data_q;
  logic              vld_p1, laser_en_q, first_px;
  logic [15:0]       line_index_q;
  logic              frame_start_q, line_done_q, underflow_q, sync_overrun_q, sop_err_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v >= 16'(V_LINES - 1)) return 16'(V_LINES - 1);
    return v + 16'd1;
  endfunction

  // End-of-frame marker carries no information the line counter needs.
  assign eop_unused = sink_endofpacket;

  assign wr_fire   = sink_valid && ready_q;
  assign sop_mid   = wr_fire && sink_startofpacket && (wcol_q != '0);
  assign wr_col    = sink_startofpacket ? '0 : wcol_q;
  assign wr_next   = wr_col + 1'b1;
  assign line_fill = wr_fire && (wr_next == COL_W'(H_PIXELS));
  assign buf_free  = line_done_q && (state_q == SCAN);

  // Reader frees rsel, writer fills wsel; they are never the same buffer.
  always_comb begin
    full_d = full_q;
    if (buf_free)  full_d[rsel_q] = 1'b0;
    if (line_fill) full_d[wsel_q] = 1'b1;
    wsel_d  = line_fill ? ~wsel_q : wsel_q;
    ready_d = ~full_d[wsel_d];
  end

  always_ff @(posedge pixel_clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      full_q    <= '0;
      first_q   <= '0;
      wsel_q    <= 1'b0;
      wcol_q    <= '0;
      ready_q   <= 1'b0;
      sop_err_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wsel_q    <= wsel_d;
      ready_q   <= ready_d;
      sop_err_q <= sop_mid;
      if (wr_fire) begin
        wcol_q <= line_fill ? '0 : wr_next;
        if (wr_col == '0) first_q[wsel_q] <= sink_startofpacket;
      end
    end
  end

  always_ff @(posedge pixel_clk_clk) begin
    if (wr_fire) begin
      if (wsel_q) buf1_q[wr_col] <= sink_data;
      else        buf0_q[wr_col] <= sink_data;
    end
    rdata_p1 <= rsel_q ? buf1_q[rd_addr] : buf0_q[rd_addr];
  end

  always_ff @(posedge pixel_clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= facet_sync_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_edge = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  // Address 0 is issued on the last DELAY cycle so pixel 0 lands two cycles later.
  assign rd_en   = ((state_q == DELAY) && (cnt_q == '0)) ||
                   ((state_q == SCAN) && (rcol_q != COL_W'(H_PIXELS)));
  assign rd_addr = ((state_q == SCAN) && (rcol_q != COL_W'(H_PIXELS))) ? rcol_q : '0;

  always_ff @(posedge pixel_clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q        <= WAIT_SYNC;
      cnt_q          <= '0;
      rcol_q         <= '0;
      rsel_q         <= 1'b0;
      underflow_q    <= 1'b0;
      sync_overrun_q <= 1'b0;
    end else begin
      underflow_q    <= sync_edge && (state_q == WAIT_SYNC) && !full_q[rsel_q];
      sync_overrun_q <= sync_edge && (state_q != WAIT_SYNC);
      case (state_q)
        WAIT_SYNC: if (sync_edge && full_q[rsel_q]) begin
          state_q <= DELAY;
          cnt_q   <= CNT_W'(DELAY_CYCLES - 1);
        end
        DELAY: if (cnt_q == '0) begin
          state_q <= SCAN;
          rcol_q  <= COL_W'(1);
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        SCAN: begin
          if (rcol_q != COL_W'(H_PIXELS)) rcol_q <= rcol_q + 1'b1;
          if (line_done_q) begin
            state_q <= WAIT_SYNC;
            rsel_q  <= ~rsel_q;
          end
        end
        default: state_q <= WAIT_SYNC;
      endcase
    end
  end

  assign first_px = vld_p1 & ~laser_en_q;

  // p1 -> output stage
  always_ff @(posedge pixel_clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      vld_p1        <= 1'b0;
      laser_en_q    <= 1'b0;
      laser_data_q  <= '0;
      line_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
      line_index_q  <= '0;
    end else begin
      vld_p1        <= rd_en;
      laser_en_q    <= vld_p1;
      laser_data_q  <= vld_p1 ? rdata_p1 : '0;
      line_done_q   <= laser_en_q & ~vld_p1;
      frame_start_q <= first_px & first_q[rsel_q];
      if (first_px) line_index_q <= first_q[rsel_q] ? 16'd0 : sat_inc(line_index_q);
    end
  end

  assign sink_ready   = ready_q;
  assign laser_data   = laser_data_q;
  assign laser_en     = laser_en_q;
  assign line_index   = line_index_q;
  assign frame_start  = frame_start_q;
  assign line_done    = line_done_q;
  assign underflow    = underflow_q;
  assign sync_overrun = sync_overrun_q;
  assign sop_err      = sop_err_q;
endmodule
